// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: issue tags and FIFO entry width.
// Host-read support is compiled in with VRAM_ARB_HOST_READ_EN.
package vram_arb_pkg;

`ifdef VRAM_ARB_HOST_READ_EN
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_FETCH = 2'd1,
        OP_HREAD = 2'd2
    } op_tag_e;
`else
    typedef enum logic [0:0] {
        OP_NONE  = 1'b0,
        OP_FETCH = 1'b1
    } op_tag_e;
`endif

    localparam int unsigned DEF_AW = 16;
    localparam int unsigned DEF_DW = 8;

    // Host FIFO entry is {we, addr, wdata}, or {addr, wdata} when reads are compiled out.
    function automatic int unsigned entry_w(input int unsigned aw, input int unsigned dw);
`ifdef VRAM_ARB_HOST_READ_EN
        return aw + dw + 1;
`else
        return aw + dw;
`endif
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Scanout, host and VRAM signals of the arbiter; slave = arbiter side, master = clients + VRAM.
interface vram_arb_if #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 8,
    parameter int unsigned FIFO_DEPTH = 4
) ();
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;
    logic          host_valid;
    logic          host_ready;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic [LW-1:0] fifo_level;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
        output fetch_data, fetch_valid, host_ready, host_rdata, host_rvalid, fifo_level,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
        input  fetch_data, fetch_valid, host_ready, host_rdata, host_rvalid, fifo_level,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_host_fifo.sv
// Synchronous host request FIFO; head is the oldest entry, pointers wrap modulo DEPTH.
module vram_host_fifo #(
    parameter int unsigned W     = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           data_i,
    output logic [W-1:0]           head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == (PW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rptr_q];

    // Full blocks pushes even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout fetch has absolute priority, host requests drain from a FIFO.
// Host reads are supported only when VRAM_ARB_HOST_READ_EN is defined.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    vram_arb_if.slave  bus
);
    localparam int unsigned EW = entry_w(AW, DW);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [EW-1:0] push_entry, head;
    logic          fifo_full, fifo_empty, host_issue, head_we;
    logic [LW-1:0] level;
    logic [AW-1:0] head_addr, last_addr_q, last_addr_d;
    logic [DW-1:0] head_wdata, fetch_hold_q, fetch_hold_d;
    op_tag_e       tag_q, tag_d;

`ifdef VRAM_ARB_HOST_READ_EN
    logic [DW-1:0] host_hold_q, host_hold_d;
    assign push_entry = {bus.host_we, bus.host_addr, bus.host_wdata};
    assign head_we    = head[EW-1];
`else
    logic unused_host_we;
    assign unused_host_we = bus.host_we;
    assign push_entry     = {bus.host_addr, bus.host_wdata};
    assign head_we        = 1'b1;
`endif

    assign head_addr  = head[DW +: AW];
    assign head_wdata = head[DW-1:0];
    // No host issue in a reset cycle: the queued request is being discarded.
    assign host_issue = !bus.fetch_req && !fifo_empty && !reset;

    vram_host_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (bus.host_valid),
        .pop_i   (host_issue),
        .data_i  (push_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign bus.host_ready = !fifo_full;
    assign bus.fifo_level = level;

    // Per-cycle grant of the memory port and the tag of what was issued.
    always_comb begin
        bus.mem_addr  = last_addr_q;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = head_wdata;
        tag_d         = OP_NONE;
        if (bus.fetch_req) begin
            bus.mem_addr = bus.fetch_addr;
            tag_d        = OP_FETCH;
        end else if (host_issue) begin
            bus.mem_addr = head_addr;
            bus.mem_we   = head_we;
`ifdef VRAM_ARB_HOST_READ_EN
            tag_d        = head_we ? OP_NONE : OP_HREAD;
`endif
        end
        last_addr_d = bus.mem_addr;
    end

    assign bus.fetch_valid = (tag_q == OP_FETCH);
    assign bus.fetch_data  = bus.fetch_valid ? bus.mem_rdata : fetch_hold_q;
    assign fetch_hold_d    = bus.fetch_data;

`ifdef VRAM_ARB_HOST_READ_EN
    assign bus.host_rvalid = (tag_q == OP_HREAD);
    assign bus.host_rdata  = bus.host_rvalid ? bus.mem_rdata : host_hold_q;
    assign host_hold_d     = bus.host_rdata;
`else
    assign bus.host_rvalid = 1'b0;
    assign bus.host_rdata  = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q        <= OP_NONE;
            last_addr_q  <= '0;
            fetch_hold_q <= '0;
`ifdef VRAM_ARB_HOST_READ_EN
            host_hold_q  <= '0;
`endif
        end else begin
            tag_q        <= tag_d;
            last_addr_q  <= last_addr_d;
            fetch_hold_q <= fetch_hold_d;
`ifdef VRAM_ARB_HOST_READ_EN
            host_hold_q  <= host_hold_d;
`endif
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: table vectors, directed sequences and a queue scoreboard.
module tb_vram_arbiter;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    vram_arb_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural VRAM: read-first, data one cycle after the address.
    logic [7:0] vram    [0:65535];
    logic [7:0] ref_mem [0:65535];
    always @(posedge clock) begin
        if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= vram[bus.mem_addr];
    end

    typedef struct { logic we; logic [15:0] addr; logic [7:0] data; } hreq_t;
    typedef struct { int cyc; logic [7:0] data; } rexp_t;
    typedef struct {
        logic fr; logic [15:0] fa; logic hv; logic hwe; logic [15:0] ha; logic [7:0] hd;
        logic exp_we; logic [2:0] exp_level;
    } vec_t;

    hreq_t hq[$];
    rexp_t fq[$];
    rexp_t rq[$];
    int    cyc = 0;
    int    n_pass = 0;
    int    n_chk = 0;
    logic [7:0] last_fd = 8'h00;
    logic [7:0] last_hd = 8'h00;

    logic        s_mem_we, s_ready, s_fv, s_rv;
    logic [15:0] s_mem_addr;
    logic [7:0]  s_mem_wdata, s_fd, s_hd;
    logic [2:0]  s_level;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // One clock cycle: drive, sample at negedge, score, then advance past the rising edge.
    task automatic step(input logic fr, input logic [15:0] fa, input logic hv, input logic hwe,
                        input logic [15:0] ha, input logic [7:0] hd, input logic rst,
                        output logic acc);
        int    sz;
        hreq_t h;
        rexp_t r;
        logic  exp_v;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.host_valid = hv;
        bus.host_we    = hwe;
        bus.host_addr  = ha;
        bus.host_wdata = hd;
        reset          = rst;
        @(negedge clock);
        s_mem_we = bus.mem_we;  s_mem_addr = bus.mem_addr; s_mem_wdata = bus.mem_wdata;
        s_ready  = bus.host_ready; s_level = bus.fifo_level;
        s_fv = bus.fetch_valid; s_fd = bus.fetch_data; s_rv = bus.host_rvalid; s_hd = bus.host_rdata;
        sz  = hq.size();
        acc = 1'b0;
        if (!rst) begin
            chk("fifo_level", 32'(s_level), 32'(sz));
            chk("host_ready", 32'(s_ready), 32'(sz < int'(DEPTH)));
            exp_v = (fq.size() > 0) && (fq[0].cyc == cyc);
            chk("fetch_valid", 32'(s_fv), 32'(exp_v));
            if (exp_v) begin r = fq.pop_front(); last_fd = r.data; end
            chk("fetch_data", 32'(s_fd), 32'(last_fd));
            exp_v = (rq.size() > 0) && (rq[0].cyc == cyc);
            chk("host_rvalid", 32'(s_rv), 32'(exp_v));
            if (exp_v) begin r = rq.pop_front(); last_hd = r.data; end
            chk("host_rdata", 32'(s_hd), 32'(last_hd));
            if (fr) begin
                chk("mem_we_fetch", 32'(s_mem_we), 32'd0);
                chk("mem_addr_fetch", 32'(s_mem_addr), 32'(fa));
                fq.push_back('{cyc + 1, pat(fa)});
            end else if (sz > 0) begin
                h = hq.pop_front();
                chk("mem_we_host", 32'(s_mem_we), 32'(h.we));
                chk("mem_addr_host", 32'(s_mem_addr), 32'(h.addr));
                if (h.we) chk("mem_wdata_host", 32'(s_mem_wdata), 32'(h.data));
                else rq.push_back('{cyc + 1, h.data});
            end else begin
                chk("mem_we_idle", 32'(s_mem_we), 32'd0);
            end
            acc = hv && (sz < int'(DEPTH));
            if (acc) begin
`ifdef VRAM_ARB_HOST_READ_EN
                h.we = hwe;
`else
                h.we = 1'b1;
`endif
                h.addr = ha;
                if (h.we) begin ref_mem[ha] = hd; h.data = hd; end
                else h.data = ref_mem[ha];
                hq.push_back(h);
            end
        end else begin
            hq.delete(); fq.delete(); rq.delete();
            last_fd = 8'h00; last_hd = 8'h00;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, a);
    endtask

    vec_t vt[8];

    initial begin
        logic acc;
        int   cnt, nacc;
        for (int i = 0; i < 65536; i++) begin
            vram[i]    = pat(16'(i));
            ref_mem[i] = pat(16'(i));
        end
        vt[0] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 8'h11, 1'b0, 3'd0};
        vt[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0101, 8'h22, 1'b1, 3'd1};
        vt[2] = '{1'b1, 16'h8001, 1'b1, 1'b1, 16'h0102, 8'h33, 1'b0, 3'd1};
        vt[3] = '{1'b1, 16'h8002, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 3'd2};
        vt[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0103, 8'h44, 1'b1, 3'd2};
        vt[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 3'd2};
        vt[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 3'd1};
        vt[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 3'd0};

        // Reset, then idle with reset values
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, acc);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, acc);
        idle(1);
        chk("rst_mem_addr", 32'(s_mem_addr), 32'h0);
        chk("rst_fetch_data", 32'(s_fd), 32'h0);
        chk("rst_host_rdata", 32'(s_hd), 32'h0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin idle(1); if (s_mem_we || !s_ready) cnt++; end
        chk("rst_idle_we_ready", 32'(cnt), 32'd0);

        // Single host write, issued exactly one cycle after acceptance
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h1234, 8'hA5, 1'b0, acc);
        chk("b_accept", 32'(acc), 32'd1);
        idle(1);
        chk("b_mem_we", 32'(s_mem_we), 32'd1);
        chk("b_mem_addr", 32'(s_mem_addr), 32'h1234);
        chk("b_mem_wdata", 32'(s_mem_wdata), 32'hA5);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            step(vt[i].fr, vt[i].fa, vt[i].hv, vt[i].hwe, vt[i].ha, vt[i].hd, 1'b0, acc);
            chk("vec_mem_we", 32'(s_mem_we), 32'(vt[i].exp_we));
            chk("vec_level", 32'(s_level), 32'(vt[i].exp_level));
        end

        // Fetch held 20 cycles while host offers 5 writes
        nacc = 0; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'(16'h8000 + i), nacc < 5, 1'b1, 16'(16'h0200 + nacc), 8'(8'hC0 + nacc), 1'b0, acc);
            if (acc) nacc++;
            if (s_mem_we) cnt++;
        end
        chk("c_accepted", 32'(nacc), 32'd4);
        chk("c_ready_low", 32'(s_ready), 32'd0);
        chk("c_no_we", 32'(cnt), 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("c_drain_we", 32'(s_mem_we), 32'd1);
            chk("c_drain_addr", 32'(s_mem_addr), 32'(16'h0200 + k));
        end

        // Write then read back the same address
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 8'h3C, 1'b0, acc);
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 8'h99, 1'b0, acc);
        cnt = 0;
`ifdef VRAM_ARB_HOST_READ_EN
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (s_rv) begin cnt++; chk("d_rdata", 32'(s_hd), 32'h3C); end
        end
        chk("d_rvalid_pulses", 32'(cnt), 32'd1);
`else
        idle(1);
        chk("d_read_is_write", 32'(s_mem_we), 32'd1);
        for (int i = 0; i < 4; i++) begin idle(1); if (s_rv) cnt++; end
        chk("d_no_rvalid", 32'(cnt), 32'd0);
`endif

        // Alternating fetch with the FIFO kept full
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'(16'h8100 + i), 1'b1, 1'b1, 16'(16'h0400 + i), 8'(i), 1'b0, acc);
        chk("e_full", 32'(s_level), 32'd3);
        for (int i = 0; i < 12; i++)
            step(i[0], 16'(16'h8200 + i), 1'b1, 1'b1, 16'(16'h0410 + i), 8'(8'h80 + i), 1'b0, acc);
        idle(8);
        chk("e_drained", 32'(s_level), 32'd0);

        // Reset with three queued entries, read at the head
        step(1'b1, 16'h8300, 1'b1, 1'b0, 16'h0300, 8'h55, 1'b0, acc);
        step(1'b1, 16'h8301, 1'b1, 1'b1, 16'h0301, 8'h77, 1'b0, acc);
        step(1'b1, 16'h8302, 1'b1, 1'b1, 16'h0302, 8'h78, 1'b0, acc);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, acc);
        idle(1);
        chk("f_level", 32'(s_level), 32'd0);
        cnt = (s_rv || s_mem_we) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin idle(1); if (s_rv || s_mem_we) cnt++; end
        chk("f_quiet", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port synchronous video RAM between the VGA scanout fetcher and a host write/read port. Sits between the pixel pipeline (driven by the horizontal/vertical counters) and the VRAM. Scanout has absolute priority because it carries the pixel deadline. Host requests are buffered in a small FIFO and drained into free memory cycles.

## Interface
Parameters:
- AW, 16, VRAM address width
- DW, 8, VRAM data width
- FIFO_DEPTH, 4, host request FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  single system/pixel clock, rising edge
- reset  in  1  synchronous, active-high
- fetch_req  in  1  scanout needs a VRAM word this cycle
- fetch_addr  in  AW  scanout address, valid with fetch_req
- fetch_data  out  DW  scanout read data
- fetch_valid  out  1  fetch_data valid, exactly 1 cycle after fetch_req
- host_valid  in  1  host request offered
- host_ready  out  1  FIFO can accept (= not full)
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_rdata  out  DW  host read data
- host_rvalid  out  1  host_rdata valid, single-cycle pulse
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- mem_addr  out  AW  to VRAM
- mem_we  out  1  to VRAM
- mem_wdata  out  DW  to VRAM
- mem_rdata  in  DW  from VRAM, valid 1 cycle after read address

## Operation
- Host handshake: transfer when host_valid && host_ready; entry {we, addr, wdata} pushed at that edge.
- host_ready = !full; asserted low when full even if a pop occurs in the same cycle.
- Per-cycle grant: fetch_req=1 → mem driven from fetch_addr, mem_we=0, FIFO untouched. fetch_req=0 and FIFO non-empty → mem driven from FIFO head, head popped at that edge. Otherwise mem_we=0, mem_addr holds last value.
- mem_addr/mem_we/mem_wdata are combinational from fetch_req, fetch_addr and the registered FIFO head.
- Issue tag register (OP_NONE, OP_FETCH, OP_HREAD) records what was issued; next cycle routes mem_rdata: OP_FETCH → fetch_data, fetch_valid=1; OP_HREAD → host_rdata, host_rvalid=1.
- fetch_data and host_rdata hold last value between valid pulses.
- Host requests complete strictly in acceptance order; a read after a write to the same address returns the new data.
- Host starvation is permitted while fetch_req stays high; no timeout.

## Timing
- Reset: FIFO empty, fifo_level=0, host_ready=1 the cycle after reset, tag=OP_NONE, fetch_valid=0, host_rvalid=0, fetch_data=0, host_rdata=0, mem_we=0, mem_addr=0.
- Reset mid-operation: buffered requests discarded; read issued in the reset cycle yields no host_rvalid.
- Fetch latency: exactly 1 cycle, independent of FIFO state.
- Host minimum latency: accepted at edge N → issued to memory in cycle N+1 (if fetch_req=0) → read data at N+2.
- Push and pop in same cycle: fifo_level unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Configuration
- VRAM_ARB_HOST_READ_EN defined: host reads supported as above.
- Undefined: host_we ignored, every entry is a write; FIFO entry omits we bit; host_rvalid and host_rdata tied 0; tag has no OP_HREAD.

## Structure
- Package vram_arb_pkg: op tag enum (OP_NONE, OP_FETCH, OP_HREAD), FIFO entry struct/width constants.
- Sub-module vram_host_fifo: synchronous FIFO with push/pop, full, empty, level, head output.

## Test plan
- Reset then idle: all outputs at reset values, host_ready=1, mem_we=0 for 10 cycles.
- Host write 0x1234←0xA5 with fetch_req=0: mem_we=1, mem_addr=0x1234, mem_wdata=0xA5 exactly one cycle after acceptance.
- fetch_req held high 20 cycles while host pushes 5 writes: 4 accepted, host_ready=0 after 4th, mem_we never 1; after fetch_req drops, 4 writes issued in order on consecutive cycles.
- Write 0x0010←0x3C then read 0x0010 (HOST_READ_EN): host_rvalid pulses once with host_rdata=0x3C.
- Alternating fetch_req every cycle with FIFO full: fetch_valid exactly 1 cycle after each fetch_req, host entries issued only in gap cycles.
- Assert reset with 3 entries queued including a read: fifo_level=0 next cycle, no host_rvalid, no mem_we afterwards.
